// File: rtl/mide_pkg.sv
// Shared types and widths for the data-memory arbiter slice.
package mide_pkg;
  localparam int LINE_W    = 128;
  localparam int LANE_W    = 32;
  localparam int NUM_LANES = LINE_W / LANE_W;
  localparam int BE_W      = LINE_W / 8;

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VGA} owner_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, VGA and RAM-side signal bundle of dmem_arbiter; slave is the arbiter view.
interface dmem_arbiter_if #(parameter int ADDR_W = 16);
  import mide_pkg::*;

  logic                  cpu_req;
  logic                  cpu_we;
  logic                  cpu_vec;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [LINE_W-1:0]     cpu_wdata;
  logic                  cpu_stall;
  logic [LINE_W-1:0]     cpu_rdata;
  logic                  cpu_rvalid;

  logic                  vga_req;
  logic [ADDR_W-3:0]     vga_addr;
  logic                  vga_gnt;
  logic [LINE_W-1:0]     vga_rdata;
  logic                  vga_rvalid;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-3:0]     mem_addr;
  logic [BE_W-1:0]       mem_be;
  logic [LINE_W-1:0]     mem_wdata;
  logic [LINE_W-1:0]     mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_vec, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    output cpu_stall, cpu_rdata, cpu_rvalid, vga_gnt, vga_rdata, vga_rvalid,
           mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_vec, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid, vga_gnt, vga_rdata, vga_rvalid,
           mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dmem_lane_unit.sv
// CPU lane handling: scalar/vector byte enables and write data on the way in,
// lane extraction with zero-extension on the way out.
module dmem_lane_unit
  import mide_pkg::*;
(
  input  logic [1:0]        lane,
  input  logic              vec,
  input  logic [LINE_W-1:0] wdata,
  output logic [BE_W-1:0]   be,
  output logic [LINE_W-1:0] line_wdata,
  input  logic [1:0]        rd_lane,
  input  logic              rd_vec,
  input  logic [LINE_W-1:0] line_rdata,
  output logic [LINE_W-1:0] rdata
);
  logic [NUM_LANES-1:0][LANE_W/8-1:0] be_lanes;
  logic [NUM_LANES-1:0][LANE_W-1:0]   wd_lanes;
  logic [NUM_LANES-1:0][LANE_W-1:0]   rd_lanes;

  // Scalar writes replicate the word to every lane; byte enables pick the real one.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign be_lanes[i] = (vec || lane == 2'(i)) ? '1 : '0;
    assign wd_lanes[i] = vec ? wdata[i*LANE_W +: LANE_W] : wdata[LANE_W-1:0];
  end

  assign be         = be_lanes;
  assign line_wdata = wd_lanes;
  assign rd_lanes   = line_rdata;
  assign rdata      = rd_vec ? line_rdata : {{(LINE_W-LANE_W){1'b0}}, rd_lanes[rd_lane]};
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: VGA priority, CPU wins after STARVE_MAX denials.
// Define DMEM_ARB_STATS_EN to add stall-cycle and VGA-grant statistics outputs.
module dmem_arbiter
  import mide_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_cpu_stall_cycles,
  output logic [31:0] stat_vga_grants
`endif
);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]        starve_cnt;
  owner_t            rd_own;
  logic [1:0]        rd_lane;
  logic              rd_vec;
  logic              cpu_gnt;
  logic              vga_gnt;
  logic              cpu_wr;
  logic [BE_W-1:0]   lane_be;
  logic [LINE_W-1:0] lane_wdata;
  logic [LINE_W-1:0] cpu_line_rdata;

  assign cpu_gnt = bus.cpu_req & (~bus.vga_req | (starve_cnt == STARVE_LIM));
  assign vga_gnt = bus.vga_req & ~cpu_gnt;
  assign cpu_wr  = cpu_gnt & bus.cpu_we;

  dmem_lane_unit u_lane (
    .lane       (bus.cpu_addr[1:0]),
    .vec        (bus.cpu_vec),
    .wdata      (bus.cpu_wdata),
    .be         (lane_be),
    .line_wdata (lane_wdata),
    .rd_lane    (rd_lane),
    .rd_vec     (rd_vec),
    .line_rdata (bus.mem_rdata),
    .rdata      (cpu_line_rdata)
  );

  // RAM side is zeroed on idle cycles; byte enables and data only matter for writes.
  always_comb begin
    bus.mem_en    = cpu_gnt | vga_gnt;
    bus.mem_we    = cpu_wr;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    if (cpu_gnt)      bus.mem_addr = bus.cpu_addr[ADDR_W-1:2];
    else if (vga_gnt) bus.mem_addr = bus.vga_addr;
    if (cpu_wr) begin
      bus.mem_be    = lane_be;
      bus.mem_wdata = lane_wdata;
    end
  end

  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  assign bus.vga_gnt    = vga_gnt;
  assign bus.cpu_rvalid = (rd_own == OWN_CPU);
  assign bus.vga_rvalid = (rd_own == OWN_VGA);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? cpu_line_rdata : '0;
  assign bus.vga_rdata  = bus.vga_rvalid ? bus.mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      rd_own     <= OWN_NONE;
      rd_lane    <= '0;
      rd_vec     <= 1'b0;
    end else begin
      if (bus.cpu_stall) begin
        if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
      rd_own <= OWN_NONE;
      if (cpu_gnt && !bus.cpu_we) begin
        rd_own  <= OWN_CPU;
        rd_lane <= bus.cpu_addr[1:0];
        rd_vec  <= bus.cpu_vec;
      end else if (vga_gnt) begin
        rd_own  <= OWN_VGA;
        rd_vec  <= 1'b1;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cpu_stall_cycles <= '0;
      stat_vga_grants       <= '0;
    end else begin
      if (bus.cpu_stall) stat_cpu_stall_cycles <= stat_cpu_stall_cycles + 32'd1;
      if (vga_gnt)       stat_vga_grants       <= stat_vga_grants + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, starvation/reset sequences, random run vs. reference model.
// With DMEM_ARB_STATS_EN defined the statistics outputs are checked as well.
module tb_dmem_arbiter;
  import mide_pkg::*;
  localparam int ADDR_W     = 16;
  localparam int STARVE_MAX = 4;
  localparam int LINES      = 64;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_cpu_stall_cycles;
  logic [31:0] stat_vga_grants;
`endif

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_cpu_stall_cycles (stat_cpu_stall_cycles),
    .stat_vga_grants       (stat_vga_grants)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0103);
  endfunction

  // RAM macro stand-in: synchronous read, byte-enabled write.
  logic [LINE_W-1:0] ram [LINES];
  initial for (int l = 0; l < LINES; l++)
    ram[l] <= {init_word(4*l+3), init_word(4*l+2), init_word(4*l+1), init_word(4*l)};
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < BE_W; b++)
          if (bus.mem_be[b]) ram[bus.mem_addr[5:0]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr[5:0]];
      end
    end
  end

  // Reference memory contents, one 32-bit word per CPU word address.
  logic [31:0] refw [LINES*4];
  function automatic logic [127:0] line_of(input int l);
    return {refw[4*l+3], refw[4*l+2], refw[4*l+1], refw[4*l]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, 128'(act), 128'(exp));
  endtask

  task automatic set_in(input logic creq, input logic cwe, input logic cvec, input logic [15:0] caddr,
                        input logic [127:0] cwd, input logic vreq, input logic [13:0] vaddr);
    bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_vec = cvec;
    bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
    bus.vga_req = vreq; bus.vga_addr = vaddr;
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic cvec, input logic [15:0] caddr,
                       input logic [127:0] cwd, input logic vreq, input logic [13:0] vaddr);
    @(posedge clk); #1;
    set_in(creq, cwe, cvec, caddr, cwd, vreq, vaddr);
  endtask

  task automatic chk_zero(input string tag);
    chkb({tag, " stall"},  bus.cpu_stall,  L);
    chkb({tag, " vgnt"},   bus.vga_gnt,    L);
    chkb({tag, " crv"},    bus.cpu_rvalid, L);
    chkb({tag, " vrv"},    bus.vga_rvalid, L);
    chkb({tag, " en"},     bus.mem_en,     L);
    chkb({tag, " we"},     bus.mem_we,     L);
    chk({tag, " addr"},    128'(bus.mem_addr), '0);
    chk({tag, " be"},      128'(bus.mem_be),   '0);
    chk({tag, " wdata"},   bus.mem_wdata,  '0);
    chk({tag, " crdata"},  bus.cpu_rdata,  '0);
    chk({tag, " vrdata"},  bus.vga_rdata,  '0);
  endtask

  // CPU read of word 0x88 against continuous VGA reads of line 33.
  task automatic starve_seq(input bit trailing);
    for (int c = 1; c <= 5; c++) begin
      drive(H, L, L, 16'h0088, '0, H, 14'd33);
      @(negedge clk);
      chkb($sformatf("starve c%0d stall", c), bus.cpu_stall, c <= 4);
      chkb($sformatf("starve c%0d vgnt", c),  bus.vga_gnt,   c <= 4);
      chk($sformatf("starve c%0d addr", c),   128'(bus.mem_addr), 128'(c <= 4 ? 33 : 34));
      chkb($sformatf("starve c%0d excl", c),  bus.cpu_rvalid & bus.vga_rvalid, L);
      if (c > 1) begin
        chkb($sformatf("starve c%0d vrv", c), bus.vga_rvalid, H);
        chk($sformatf("starve c%0d vrd", c),  bus.vga_rdata, line_of(33));
      end
    end
    drive(L, L, L, 16'h0, '0, trailing, 14'd33);
    @(negedge clk);
    chkb("starve crv", bus.cpu_rvalid, H);
    chk("starve crd",  bus.cpu_rdata, {96'b0, refw[136]});
    chkb("starve vrv_gap", bus.vga_rvalid, L);
    if (trailing) begin
      chkb("starve regrant vgnt", bus.vga_gnt, H);
      chkb("starve regrant stall", bus.cpu_stall, L);
      drive(L, L, L, 16'h0, '0, L, 14'd0);
      @(negedge clk);
      chkb("starve regrant vrv", bus.vga_rvalid, H);
    end
  endtask

  typedef struct {
    logic creq, cwe, cvec; logic [15:0] caddr; logic [127:0] cwd;
    logic vreq; logic [13:0] vaddr;
    logic e_stall, e_vgnt, e_en, e_we; logic [13:0] e_addr; logic [15:0] e_be; logic [127:0] e_wd;
    logic e_crv; logic [127:0] e_crd; logic e_vrv; logic [127:0] e_vrd;
  } vec_t;

  function automatic vec_t mk(
    input logic creq, input logic cwe, input logic cvec, input logic [15:0] caddr, input logic [127:0] cwd,
    input logic vreq, input logic [13:0] vaddr,
    input logic e_stall, input logic e_vgnt, input logic e_en, input logic e_we,
    input logic [13:0] e_addr, input logic [15:0] e_be, input logic [127:0] e_wd,
    input logic e_crv, input logic [127:0] e_crd, input logic e_vrv, input logic [127:0] e_vrd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.cvec = cvec; v.caddr = caddr; v.cwd = cwd;
    v.vreq = vreq; v.vaddr = vaddr;
    v.e_stall = e_stall; v.e_vgnt = e_vgnt; v.e_en = e_en; v.e_we = e_we;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wd = e_wd;
    v.e_crv = e_crv; v.e_crd = e_crd; v.e_vrv = e_vrv; v.e_vrd = e_vrd;
    return v;
  endfunction

  initial begin
    vec_t tv[$];
    logic [31:0]  db, w5, w7;
    logic [127:0] v1, hi;
    logic creq, cwe, cvec, vreq;
    logic [15:0] caddr;
    logic [127:0] cwd;
    logic [13:0] vaddr;
    bit   cwin, vwin, p_cv, p_vv;
    logic [127:0] p_cd, p_vd;
    logic [13:0]  e_addr;
    logic [15:0]  e_be;
    logic [127:0] e_wd;
    int wait_n, stall_run;

    for (int i = 0; i < LINES*4; i++) refw[i] = init_word(i);
    set_in(L, L, L, 16'h0, '0, L, 14'h0);

    db = 32'hDEAD_BEEF; w5 = 32'h1122_3344; w7 = 32'hCAFE_F00D;
    v1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    hi = {96'hFFFF_0000_1234_5678_9ABC_DEF0, 32'h0};
    tv.push_back(mk(L,L,L,16'h0000,'0,           L,14'h0, L,L,L,L,14'h0,16'h0000,'0,        L,'0,L,'0));
    tv.push_back(mk(H,H,L,16'h0006,hi|128'(db),  L,14'h0, L,L,H,H,14'h1,16'h0F00,{4{db}},   L,'0,L,'0));
    tv.push_back(mk(H,L,L,16'h0006,'0,           L,14'h0, L,L,H,L,14'h1,16'h0000,'0,        L,'0,L,'0));
    tv.push_back(mk(L,L,L,16'h0000,'0,           L,14'h0, L,L,L,L,14'h0,16'h0000,'0,        H,{96'b0,db},L,'0));
    tv.push_back(mk(H,H,H,16'h0010,v1,           L,14'h0, L,L,H,H,14'h4,16'hFFFF,v1,        L,'0,L,'0));
    tv.push_back(mk(H,L,H,16'h0013,'0,           L,14'h0, L,L,H,L,14'h4,16'h0000,'0,        L,'0,L,'0));
    tv.push_back(mk(H,H,L,16'h0005,{96'b0,w5},   H,14'h4, H,H,H,L,14'h4,16'h0000,'0,        H,v1,L,'0));
    tv.push_back(mk(H,H,L,16'h0005,{96'b0,w5},   L,14'h0, L,L,H,H,14'h1,16'h00F0,{4{w5}},   L,'0,H,v1));
    tv.push_back(mk(H,L,L,16'h0005,'0,           L,14'h0, L,L,H,L,14'h1,16'h0000,'0,        L,'0,L,'0));
    tv.push_back(mk(L,L,L,16'h0000,'0,           H,14'h1, L,H,H,L,14'h1,16'h0000,'0,        H,{96'b0,w5},L,'0));
    tv.push_back(mk(H,H,L,16'h0007,{96'b0,w7},   L,14'h0, L,L,H,H,14'h1,16'hF000,{4{w7}},   L,'0,H,
                    {init_word(7),db,w5,init_word(4)}));
    tv.push_back(mk(H,L,H,16'h0004,'0,           L,14'h0, L,L,H,L,14'h1,16'h0000,'0,        L,'0,L,'0));
    tv.push_back(mk(L,L,L,16'h0000,'0,           L,14'h0, L,L,L,L,14'h0,16'h0000,'0,        H,{w7,db,w5,init_word(4)},L,'0));
    tv.push_back(mk(H,L,L,16'h0007,'0,           L,14'h0, L,L,H,L,14'h1,16'h0000,'0,        L,'0,L,'0));
    tv.push_back(mk(L,L,L,16'h0000,'0,           L,14'h0, L,L,L,L,14'h0,16'h0000,'0,        H,{96'b0,w7},L,'0));

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i].creq, tv[i].cwe, tv[i].cvec, tv[i].caddr, tv[i].cwd, tv[i].vreq, tv[i].vaddr);
      @(negedge clk);
      chkb($sformatf("t%0d stall", i), bus.cpu_stall, tv[i].e_stall);
      chkb($sformatf("t%0d vgnt", i),  bus.vga_gnt,   tv[i].e_vgnt);
      chkb($sformatf("t%0d en", i),    bus.mem_en,    tv[i].e_en);
      chkb($sformatf("t%0d we", i),    bus.mem_we,    tv[i].e_we);
      chk($sformatf("t%0d addr", i),   128'(bus.mem_addr), 128'(tv[i].e_addr));
      chk($sformatf("t%0d be", i),     128'(bus.mem_be),   128'(tv[i].e_be));
      chk($sformatf("t%0d wdata", i),  bus.mem_wdata, tv[i].e_wd);
      chkb($sformatf("t%0d crv", i),   bus.cpu_rvalid, tv[i].e_crv);
      chkb($sformatf("t%0d vrv", i),   bus.vga_rvalid, tv[i].e_vrv);
      if (tv[i].e_crv) chk($sformatf("t%0d crd", i), bus.cpu_rdata, tv[i].e_crd);
      if (tv[i].e_vrv) chk($sformatf("t%0d vrd", i), bus.vga_rdata, tv[i].e_vrd);
    end

    starve_seq(1'b1);

    // Build up some starvation, grant a VGA read, then reset before its data returns.
    for (int c = 1; c <= 3; c++) begin
      drive(H, L, L, 16'h0088, '0, H, 14'd33);
      @(negedge clk);
      chkb($sformatf("prerst c%0d stall", c), bus.cpu_stall, H);
      chkb($sformatf("prerst c%0d vgnt", c),  bus.vga_gnt,   H);
    end
    rst = 1'b0;
    set_in(L, L, L, 16'h0, '0, L, 14'h0);
    #1;
    chk_zero("in_reset");
    @(negedge clk);
    chk_zero("reset_hold");
    rst = 1'b1;
    drive(L, L, L, 16'h0, '0, L, 14'h0);
    @(negedge clk);
    chkb("post_rst vrv", bus.vga_rvalid, L);
    chkb("post_rst crv", bus.cpu_rvalid, L);

    repeat (3) starve_seq(1'b0);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_stall_cycles", 128'(stat_cpu_stall_cycles), 128'(12));
    chk("stat_vga_grants",   128'(stat_vga_grants),       128'(12));
`endif

    // Random traffic on lines 32..63 against the reference model.
    creq = L; cwe = L; cvec = L; caddr = '0; cwd = '0; vreq = L; vaddr = '0;
    cwin = 1'b0; vwin = 1'b0; p_cv = 1'b0; p_vv = 1'b0; p_cd = '0; p_vd = '0;
    wait_n = 0; stall_run = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (!(creq && !cwin)) begin
        creq  = ($urandom_range(0, 3) != 0);
        cwe   = 1'($urandom_range(0, 1));
        cvec  = 1'($urandom_range(0, 1));
        caddr = 16'(128 + $urandom_range(0, 127));
        cwd   = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!(vreq && !vwin)) begin
        vreq  = ($urandom_range(0, 2) == 0);
        vaddr = 14'(32 + $urandom_range(0, 31));
      end
      set_in(creq, cwe, cvec, caddr, cwd, vreq, vaddr);
      @(negedge clk);

      chkb("rnd crv", bus.cpu_rvalid, p_cv);
      chkb("rnd vrv", bus.vga_rvalid, p_vv);
      if (p_cv) chk("rnd crd", bus.cpu_rdata, p_cd);
      if (p_vv) chk("rnd vrd", bus.vga_rdata, p_vd);

      cwin = creq && (!vreq || wait_n == STARVE_MAX);
      vwin = vreq && !cwin;
      e_addr = cwin ? caddr[15:2] : (vwin ? vaddr : 14'h0);
      e_be   = (cwin && cwe) ? (cvec ? 16'hFFFF : 16'(16'hF << (4 * caddr[1:0]))) : 16'h0;
      e_wd   = (cwin && cwe) ? (cvec ? cwd : {4{cwd[31:0]}}) : '0;
      chkb("rnd stall", bus.cpu_stall, creq && !cwin);
      chkb("rnd vgnt",  bus.vga_gnt,   vwin);
      chkb("rnd en",    bus.mem_en,    cwin || vwin);
      chkb("rnd we",    bus.mem_we,    cwin && cwe);
      chk("rnd addr",   128'(bus.mem_addr), 128'(e_addr));
      chk("rnd be",     128'(bus.mem_be),   128'(e_be));
      chk("rnd wdata",  bus.mem_wdata, e_wd);

      stall_run = bus.cpu_stall ? stall_run + 1 : 0;
      chkb("rnd stall_bound", stall_run <= STARVE_MAX, H);

      wait_n = (creq && !cwin) ? wait_n + 1 : 0;
      p_cv = cwin && !cwe;
      p_vv = vwin;
      if (p_cv) p_cd = cvec ? line_of(int'(caddr[15:2])) : {96'b0, refw[caddr[7:0]]};
      if (p_vv) p_vd = line_of(int'(vaddr));
      if (cwin && cwe) begin
        if (cvec) for (int k = 0; k < 4; k++) refw[{caddr[7:2], 2'(k)}] = cwd[k*32 +: 32];
        else refw[caddr[7:0]] = cwd[31:0];
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port, 128-bit-wide data/image RAM between the CPU MEM stage (scalar 32-bit and vector 128-bit load/store) and the VGA frame reader. Sits between the EX/MEM pipeline register outputs, the VGA scanout logic and the RAM macro. Arbitrates per cycle with VGA priority and a bounded-starvation guarantee for the CPU. Drives the CPU pipeline stall when the CPU loses arbitration.

## Interface
- ADDR_W, 16, word address width; the RAM is addressed in 128-bit lines, with addr[1:0] selecting the 32-bit lane.
- STARVE_MAX, 4, consecutive denied CPU cycles after which the CPU wins over VGA; legal range is 1..15.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held stable while cpu_stall=1.
- cpu_we  in  1  write (1) or read (0).
- cpu_vec  in  1  selects a 128-bit vector access (1) or a 32-bit scalar access (0).
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  128  write data; scalar writes use bits [31:0].
- cpu_stall  out  1  CPU request present and not granted this cycle.
- cpu_rdata  out  128  read data; scalar reads are zero-extended.
- cpu_rvalid  out  1  cpu_rdata valid.
- vga_req  in  1  frame-reader line request; held until granted.
- vga_addr  in  ADDR_W-2  line address.
- vga_gnt  out  1  VGA request accepted this cycle.
- vga_rdata  out  128  read data.
- vga_rvalid  out  1  vga_rdata valid.
- mem_en, mem_we  out  1 each  RAM enable and write enable.
- mem_addr  out  ADDR_W-2  RAM line address.
- mem_be  out  16  byte enables.
- mem_wdata  out  128  RAM write data.
- mem_rdata  in  128  RAM read data; synchronous, returns 1 cycle after mem_en.

## Operation
- Grant logic is combinational from the current requests and the registered starvation count. Rules, in order:
  - vga_req & cpu_req & starve_cnt==STARVE_MAX: CPU wins.
  - vga_req: VGA wins.
  - cpu_req only: CPU wins.
- cpu_stall = cpu_req & ~cpu_gnt. vga_gnt is the VGA grant.
- Starvation counter (4-bit, saturating at STARVE_MAX):
  - increments when cpu_req & ~cpu_gnt;
  - clears when the CPU is granted or cpu_req=0.
- CPU scalar access, lane = addr[1:0]:
  - write: mem_be has 4'hF at bytes lane*4..lane*4+3, and cpu_wdata[31:0] is replicated to all four lanes;
  - read: returns the selected lane zero-extended.
- CPU vector access:
  - mem_be = 16'hFFFF;
  - addr[1:0] is ignored; the line is addressed by addr[ADDR_W-1:2].
- VGA accesses are always full-line reads with mem_we=0.
- Return tracking register rd_own ∈ {NONE, CPU, VGA}, plus a 2-bit rd_lane and a 1-bit rd_vec captured on each granted read.
  - The next cycle, mem_rdata is steered to the owner and that owner's rvalid pulses for one cycle.
  - Writes leave rd_own=NONE.
- Idle cycle (no request): mem_en=0, and mem_addr, mem_be and mem_wdata are driven to 0.

## Timing
- Reset values: all outputs 0, rd_own=NONE, starve_cnt=0. Reset asserted mid-read discards the return; no rvalid pulses after reset releases.
- Grant is in the same cycle as the request. Read data latency is 1 cycle after grant. Back-to-back grants are allowed every cycle, so throughput is 1 access/cycle.
- A CPU stall lasts at most STARVE_MAX cycles while VGA requests continuously.
- cpu_rvalid and vga_rvalid are never both 1 in the same cycle.

## Configuration
- DMEM_ARB_STATS_EN defined: adds outputs stat_cpu_stall_cycles (32-bit) and stat_vga_grants (32-bit).
  - Both are free-running, wrap at 2^32 and are cleared by rst.
  - stall_cycles counts cycles with cpu_stall=1; vga_grants counts vga_gnt=1.
- Undefined: those ports and counters do not exist.

## Structure
- Shared package mide_pkg holds:
  - enum owner_t {OWN_NONE, OWN_CPU, OWN_VGA};
  - localparam LINE_W=128 and LANE_W=32.
- One sub-module, dmem_lane_unit, is natural: it performs scalar byte-enable/write-data generation and read-lane extraction. The arbiter, counter and return tracking stay in dmem_arbiter.

## Test plan
- Lone CPU scalar write: addr=0x0006, wdata[31:0]=0xDEADBEEF.
  - Expect mem_be=16'h0F00 and mem_addr=0x0001 in the same cycle, with cpu_stall=0.
  - Then a scalar read of 0x0006 gives cpu_rdata=0x0000…DEADBEEF, with cpu_rvalid 1 cycle after grant.
- Lone vector read at addr=0x0013 → mem_addr=0x0004, mem_be=0, and the full 128-bit line is returned 1 cycle later.
- Continuous vga_req and cpu_req read, STARVE_MAX=4:
  - VGA is granted for 4 cycles, the CPU is granted in cycle 5, then VGA is granted again;
  - cpu_stall is high exactly cycles 1–4.
- Alternating grants → each rvalid pulses on the correct side with the correct data, and is never asserted on both sides together.
- rst pulled low the cycle after a granted VGA read → vga_rvalid stays 0, all outputs are 0, and starve_cnt=0 after release.
- With DMEM_ARB_STATS_EN: the starvation scenario repeated 3 times gives stat_cpu_stall_cycles=12 and stat_vga_grants=12.
